digit_reader: RTL and testbench

//   Reads back a 128-bit digit buffer (32 x 4-bit, padded with 4'hF) and streams its digits

---
 rtl/digit_reader_pkg.sv | 18 +
 rtl/digit_reader.sv | 114 +++++++++++
 tb/tb_digit_reader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/digit_reader_pkg.sv
// Shared constants and state encoding for the digit buffer readout path.
// DIGITS/DW/EMPTY must match the input buffer that fills buf_in.
package digit_reader_pkg;

  localparam int unsigned DIGITS = 32;
  localparam int unsigned DW     = 4;
  localparam int unsigned CW     = $clog2(DIGITS + 1);

  localparam logic [DW-1:0] EMPTY = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StSkip,
    StStream,
    StDone
  } state_e;

endpackage

// File: rtl/digit_reader.sv
// Streams a snapshot of the digit buffer oldest-first over valid/ready,
// skipping leading padding nibbles; reports digit count and an all-padding flag.
module digit_reader
  import digit_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIGITS*DW-1:0] buf_in,
  output logic                 busy,
  output logic                 dig_valid,
  output logic [DW-1:0]        dig_data,
  output logic                 dig_last,
  input  logic                 dig_ready,
  output logic [CW-1:0]        dig_count,
  output logic                 done,
  output logic                 none_found
);

  state_e               state_q, state_d;
  logic [DIGITS*DW-1:0] sreg_q, sreg_d;
  logic [CW-1:0]        remain_q, remain_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 none_q, none_d;

  logic [DW-1:0]        top;
  logic [DIGITS*DW-1:0] shifted;

  assign top     = sreg_q[DIGITS*DW-1 -: DW];
  assign shifted = {sreg_q[DIGITS*DW-DW-1:0], EMPTY};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sreg_q   <= {DIGITS{EMPTY}};
      remain_q <= '0;
      count_q  <= '0;
      none_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      remain_q <= remain_d;
      count_q  <= count_d;
      none_q   <= none_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    remain_d = remain_q;
    count_d  = count_q;
    none_d   = none_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          sreg_d   = buf_in;
          remain_d = CW'(DIGITS);
          count_d  = '0;
          none_d   = 1'b0;
          state_d  = StSkip;
        end
      end
      StSkip: begin
        if (abort) begin
          state_d = StIdle;
        end else if (remain_q == '0) begin
          state_d = StDone;
          none_d  = 1'b1;
        end else if (top == EMPTY) begin
          sreg_d   = shifted;
          remain_d = remain_q - CW'(1);
        end else begin
          state_d = StStream;
          count_d = remain_q;
        end
      end
      StStream: begin
        // Abort takes priority: a digit offered in the same cycle is not delivered.
        if (abort) begin
          state_d = StIdle;
        end else if (dig_ready) begin
          sreg_d   = shifted;
          remain_d = remain_q - CW'(1);
          if (remain_q == CW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy       = (state_q != StIdle);
    dig_valid  = (state_q == StStream);
    dig_data   = '0;
    dig_last   = 1'b0;
    if (state_q == StStream) begin
      dig_data = top;
      dig_last = (remain_q == CW'(1));
    end
    done       = (state_q == StDone);
    dig_count  = count_q;
    none_found = none_q;
  end

endmodule

// File: tb/tb_digit_reader.sv
// Table-driven bench for digit_reader with a digit scoreboard, plus hand-written
// sequences for abort, start-while-busy and asynchronous reset.
module tb_digit_reader;
  import digit_reader_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic [DIGITS*DW-1:0] buf_in;
  logic                 busy;
  logic                 dig_valid;
  logic [DW-1:0]        dig_data;
  logic                 dig_last;
  logic                 dig_ready;
  logic [CW-1:0]        dig_count;
  logic                 done;
  logic                 none_found;

  digit_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .buf_in     (buf_in),
    .busy       (busy),
    .dig_valid  (dig_valid),
    .dig_data   (dig_data),
    .dig_last   (dig_last),
    .dig_ready  (dig_ready),
    .dig_count  (dig_count),
    .done       (done),
    .none_found (none_found)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DIGITS*DW-1:0] b;
    bit                   toggle;      // dig_ready toggles instead of held high
    int                   restart_at;  // cycle to pulse start mid-readout (0 = never)
    int                   exp_first;   // cycle of first dig_valid (0 = never)
    int                   exp_done;
    int                   exp_count;
    bit                   exp_none;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } dig_t;

  vec_t vecs[5];
  dig_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference readout: drop leading padding, everything after is data.
  task automatic build_model(input logic [DIGITS*DW-1:0] b);
    bit   lead = 1'b1;
    dig_t e;
    exp_q.delete();
    for (int i = DIGITS - 1; i >= 0; i--) begin
      e.d = b[i*DW +: DW];
      e.l = 1'b0;
      if (!(lead && e.d == 4'hF)) begin
        lead = 1'b0;
        exp_q.push_back(e);
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].l = 1'b1;
  endtask

  task automatic run_case(input vec_t v, input string tag);
    int            n = 1;
    int            first_n = 0;
    int            done_n = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;
    logic [CW-1:0] cnt_at_done = '0;
    dig_t          e;
    build_model(v.b);
    @(negedge clk);
    buf_in = v.b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    buf_in = {4{$urandom}};
    while (done_n == 0 && n < 200) begin
      if (dig_valid && first_n == 0) first_n = n;
      if (prev_stall) begin
        check({tag, " stall data"}, 32'(dig_data), 32'(prev_d));
        check({tag, " stall last"}, 32'(dig_last), 32'(prev_l));
      end
      if (done) begin
        done_n = n;
        cnt_at_done = dig_count;
        check({tag, " none_found"}, 32'(none_found), 32'(v.exp_none));
      end
      dig_ready = v.toggle ? (n % 2 == 1) : 1'b1;
      if (v.restart_at == n) begin
        start  = 1'b1;
        buf_in = ~v.b;
      end else begin
        start = 1'b0;
      end
      if (dig_valid && dig_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, " extra digit"}, 32'(dig_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check({tag, " data"}, 32'(dig_data), 32'(e.d));
          check({tag, " last"}, 32'(dig_last), 32'(e.l));
        end
      end
      prev_stall = dig_valid && !dig_ready;
      prev_d     = dig_data;
      prev_l     = dig_last;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, " first valid cycle"}, 32'(first_n), 32'(v.exp_first));
    check({tag, " done cycle"}, 32'(done_n), 32'(v.exp_done));
    check({tag, " dig_count"}, 32'(cnt_at_done), 32'(v.exp_count));
    check({tag, " digits left"}, 32'(exp_q.size()), 32'd0);
    check({tag, " busy after"}, 32'(busy), 32'd0);
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " count held"}, 32'(dig_count), 32'(v.exp_count));
    check({tag, " none held"}, 32'(none_found), 32'(v.exp_none));
  endtask

  initial begin
    int k;
    vecs[0] = '{{{29{4'hF}}, 12'h123}, 1'b0, 0, 31, 34, 3, 1'b0};
    vecs[1] = '{{32{4'hF}}, 1'b0, 0, 0, 34, 0, 1'b1};
    vecs[2] = '{{2{64'h0123_4567_89AB_CDEF}}, 1'b1, 0, 2, 66, 32, 1'b0};
    vecs[3] = '{{{29{4'hF}}, 12'h5F7}, 1'b0, 0, 31, 34, 3, 1'b0};
    vecs[4] = '{{{29{4'hF}}, 12'h123}, 1'b0, 32, 31, 34, 3, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; dig_ready = 1'b0; buf_in = '0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(dig_valid), 32'd0);
    check("reset data", 32'(dig_data), 32'd0);
    check("reset last", 32'(dig_last), 32'd0);
    check("reset count", 32'(dig_count), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset none", 32'(none_found), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_case(vecs[i], $sformatf("vec%0d", i));

    // Start with abort in IDLE stays idle.
    @(negedge clk);
    buf_in = vecs[0].b; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start+abort idle busy", 32'(busy), 32'd0);

    // Abort with the third digit on offer after two accepted.
    start = 1'b1; dig_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!dig_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("abort seq first digit", 32'(dig_data), 32'h1);
    @(negedge clk);
    check("abort seq second digit", 32'(dig_data), 32'h2);
    @(negedge clk);
    check("abort seq third offered", 32'(dig_valid), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort valid", 32'(dig_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("abort no done", 32'(done), 32'd0);
      @(negedge clk);
    end
    run_case(vecs[0], "after abort");

    // Asynchronous reset mid-stream takes effect between edges.
    buf_in = vecs[2].b; start = 1'b1; dig_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!dig_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("pre-rst valid", 32'(dig_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async rst valid", 32'(dig_valid), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst count", 32'(dig_count), 32'd0);
    #1 rst = 1'b0;
    run_case(vecs[3], "after rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
